// File: rtl/bus_arbiter.sv
// Two-master round-robin bus arbiter with bounded tenure.
// Moore FSM: grants and mux select decode only from the registered state.
module bus_arbiter #(
    parameter int HOLD_MAX = 8,
    parameter int CNT_W    = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic M0_req,
    input  logic M1_req,
    output logic M0_grant,
    output logic M1_grant,
    output logic M_sel,
    output logic bus_busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_MAX - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_owner_q, last_owner_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_owner_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_owner_q <= last_owner_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_owner_d = last_owner_q;

        case (state_q)
            IDLE: begin
                if (M0_req && M1_req) begin
                    // Tie: favour the master that did not own the bus last.
                    state_d = last_owner_q ? G0 : G1;
                end else if (M0_req) begin
                    state_d = G0;
                end else if (M1_req) begin
                    state_d = G1;
                end
            end
            G0: begin
                if (!M0_req) begin
                    state_d = M1_req ? G1 : IDLE;
                end else if (M1_req && (cnt_q == CNT_MAX)) begin
                    state_d = G1;
                end
            end
            G1: begin
                if (!M1_req) begin
                    state_d = M0_req ? G0 : IDLE;
                end else if (M0_req && (cnt_q == CNT_MAX)) begin
                    state_d = G0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
            if (state_d == G0) begin
                last_owner_d = 1'b0;
            end else if (state_d == G1) begin
                last_owner_d = 1'b1;
            end
        end else if ((state_q != IDLE) && (cnt_q != CNT_MAX)) begin
            // Uncontended cycles count too, so a long solo owner yields at once.
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign M0_grant = (state_q == G0);
    assign M1_grant = (state_q == G1);
    assign M_sel    = (state_q == G1);
    assign bus_busy = (state_q != IDLE);

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-master bus arbiter for the shared system bus. It decides which of masters M0 and M1 may drive address and data toward the slave address decoder and the S0/S1 slaves. It uses round-robin tie-breaking and a bounded tenure so that neither master starves. Its `M_sel` output steers the master-side address/write-data mux that feeds the decoder.

## Interface
- `HOLD_MAX`, default 8: maximum cycles a master keeps the grant while the other master is requesting; legal range 1..255.
- `CNT_W`, default 8: tenure counter width; must satisfy 2^CNT_W ≥ HOLD_MAX.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `M0_req`  in  1  M0 bus request, level; held high for the whole transfer.
- `M1_req`  in  1  M1 bus request, level; held high for the whole transfer.
- `M0_grant`  out  1  M0 owns the bus (registered).
- `M1_grant`  out  1  M1 owns the bus (registered).
- `M_sel`  out  1  mux select: 0 = M0 address/data, 1 = M1 address/data (registered).
- `bus_busy`  out  1  high when either grant is high (registered).

## Operation
- Moore FSM with states IDLE, G0 and G1. All outputs decode from registered state only, with no combinational path from `req` to `grant`.
- Internal registers:
  - `state`.
  - `cnt[CNT_W-1:0]`, the tenure counter.
  - `last_owner`, where 0 = M0 and 1 = M1.
- Output decode:
  - IDLE: both grants 0, `M_sel`=0, `bus_busy`=0.
  - G0: `M0_grant`=1, `M_sel`=0, `bus_busy`=1.
  - G1: `M1_grant`=1, `M_sel`=1, `bus_busy`=1.
- Reset (highest priority over every other event) sets `state`=IDLE, `cnt`=0, `last_owner`=1. After reset, all outputs are 0.
- Transitions from IDLE:
  - Only `M0_req` high: go to G0.
  - Only `M1_req` high: go to G1.
  - Both high: grant the master that is not `last_owner`.
  - Neither high: stay in IDLE.
- Transitions from G0 (G1 is symmetric with the roles swapped):
  - `M0_req`=0 and `M1_req`=1: go to G1 directly, with no idle cycle.
  - `M0_req`=0 and `M1_req`=0: go to IDLE.
  - `M0_req`=1, `M1_req`=1 and `cnt`==HOLD_MAX-1: preempt and go to G1.
  - Otherwise: stay in G0.
- Counter rules:
  - Any state change clears `cnt` to 0.
  - While staying in G0 or G1, `cnt` increments and saturates at HOLD_MAX-1.
  - `cnt` also counts uncontended cycles. A master that has held the bus alone for HOLD_MAX or more cycles is therefore preempted on the first edge at which the other master requests.
- `last_owner` is loaded on every entry into G0 (0) or G1 (1). It is unchanged when entering IDLE.
- Preemption removes the grant regardless of transfer progress. Masters must sample their grant every cycle and stall when it is low.

## Timing
- Grant latency from IDLE: a request sampled high at edge k produces a grant visible after edge k, i.e. one cycle of latency.
- Release latency: a request sampled low at edge k drops the grant after edge k.
- Handover G0↔G1 takes one edge. The old grant falls and the new grant rises at the same edge. The two grants are never high together, including across reset.
- Maximum contended tenure is exactly HOLD_MAX cycles of grant.
- With HOLD_MAX=1 and both requests held high, the grant alternates every cycle.
- Worst-case wait for a requesting master is HOLD_MAX+1 cycles.
- Reset asserted during a tenure: grants drop after that edge, and the arbiter restarts in IDLE with `last_owner`=1.

## Test plan
- Reset check: hold `reset` for 2 cycles with both requests high → all outputs 0 during reset. On the first edge after release, `M0_grant`=1 and `M_sel`=0, because `last_owner` resets to M1.
- Solo transfer: `M1_req` high for 5 cycles, then low → `M1_grant` and `M_sel` high for exactly 5 cycles, each delayed one cycle from the request; then IDLE with all outputs 0.
- Contention with HOLD_MAX=8, both requests held high → grants alternate: 8 cycles of G0, then 8 cycles of G1, then G0 again. `M0_grant` & `M1_grant` is never 1.
- Early release with direct handover: M0 granted, M1 requests at cycle 3, M0 releases at cycle 5 → `M1_grant` rises on the same edge `M0_grant` falls, with no IDLE cycle.
- Round-robin from IDLE: M1 completes a solo transfer, the bus goes IDLE, then both requests rise together → M0 is granted first. Repeat after an M0 solo transfer → M1 is granted first.
- Reset mid-tenure plus HOLD_MAX=1: assert reset while in G1 → next cycle IDLE, and M0 wins a subsequent tie. With HOLD_MAX=1 and both requests high, the grant toggles every cycle.
